// File: rtl/spi_so_receiver_if.sv
// Bus bundle for spi_so_receiver: flash pins (sub_clock, SO_in, CS_out) plus the
// burst request / byte delivery handshake.
interface spi_so_receiver_if #(parameter int LEN_W = 8);
  logic             sub_clock;
  logic             SO_in;
  logic             start;
  logic [LEN_W-1:0] byte_len;
  logic             CS_out;
  logic             busy;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             done;

  modport master (
    output sub_clock, SO_in, start, byte_len,
    input  CS_out, busy, rx_data, rx_valid, done
  );

  modport slave (
    input  sub_clock, SO_in, start, byte_len,
    output CS_out, busy, rx_data, rx_valid, done
  );
endinterface

// File: rtl/spi_so_receiver.sv
// Flash SO capture engine: frames a burst with CS_out and assembles bytes sampled on
// sub_clock rising edges. Define SPI_RX_LSB_FIRST_EN for LSB-first byte assembly.
module spi_so_receiver #(
  parameter int LEN_W = 8
) (
  input  logic             top_clk,
  input  logic             rst,
  spi_so_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sck_q;
  // Only the 7 bits preceding the current one are kept; the 8th goes straight to rx_data.
  logic [6:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;

  logic             rise_s, fall_s;
  logic [7:0]       shift_s;

  assign rise_s = bus.sub_clock & ~sck_q;
  assign fall_s = ~bus.sub_clock & sck_q;

`ifdef SPI_RX_LSB_FIRST_EN
  assign shift_s = {bus.SO_in, shreg_q};
`else
  assign shift_s = {shreg_q, bus.SO_in};
`endif

  // Next-state and output computation for the burst framing FSM.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.byte_len != {LEN_W{1'b0}})) begin
          len_d      = bus.byte_len;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = {LEN_W{1'b0}};
          state_d    = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (fall_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_SHIFT: begin
        if (rise_s) begin
`ifdef SPI_RX_LSB_FIRST_EN
          shreg_d = shift_s[7:1];
`else
          shreg_d = shift_s[6:0];
`endif
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_s;
            rx_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_q + LEN_W'(1);
            if (byte_cnt_q == (len_q - LEN_W'(1))) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FINISH: begin
        // CS releases only after SCK has gone low again.
        if (fall_s) begin
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge top_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sck_q      <= 1'b0;
      shreg_q    <= 7'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= bus.sub_clock;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.CS_out   = cs_q;
  assign bus.busy     = busy_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_so_receiver.sv
// Bench for spi_so_receiver: directed burst table, corner sequences and randomized
// bursts, all compared cycle by cycle against a burst-level reference model.
module tb_spi_so_receiver;

  localparam int PH_IDLE = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_CAP  = 2;
  localparam int PH_REL  = 3;

  typedef struct {
    logic [7:0]      len;
    logic [2:0][7:0] wire_b;
    int              exp_valid;
    int              exp_done;
  } vec_t;

  logic top_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 top_clk = ~top_clk;

  spi_so_receiver_if #(.LEN_W(8)) bus ();

  spi_so_receiver #(.LEN_W(8)) dut (
    .top_clk (top_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int   checks   = 0;
  int   failures = 0;

  int   hp       = 2;
  int   div_cnt  = 0;
  logic sc_drv   = 1'b0;
  logic sc_old   = 1'b0;
  logic so_drv   = 1'b0;
  bit   tx_bits[$];

  int         m_phase = PH_IDLE;
  int         m_cnt   = 0;
  int         m_total = 0;
  logic       m_prev  = 1'b0;
  logic       m_cs    = 1'b1;
  logic       m_busy  = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_done  = 1'b0;
  logic [7:0] m_rx    = 8'h00;
  bit         m_bits[$];

  logic [7:0] got[$];
  int         done_cnt  = 0;
  int         cs_rises  = 0;
  bit         seen_fall = 1'b0;

  vec_t tbl[5];

  // Byte the receiver should deliver for a byte sent MSB-first on the wire.
  function automatic logic [7:0] rx_of(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic [7:0] assemble(input int dummy);
    int v = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      v = v + (int'(m_bits[i]) << i);
`else
      v = v * 2 + int'(m_bits[i]);
`endif
    end
    return v[7:0] + 8'(dummy);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(w[i]);
  endtask

  task automatic step(input logic st, input logic [7:0] len, input logic r);
    logic rise_m, fall_m;
    @(negedge top_clk);
    sc_old = sc_drv;
    div_cnt++;
    if (div_cnt >= hp) begin
      div_cnt = 0;
      sc_drv  = ~sc_drv;
    end
    rise_m = sc_drv & ~m_prev;
    fall_m = ~sc_drv & m_prev;
    so_drv = 1'($urandom_range(0, 1));
    if (!r && m_phase == PH_CAP && rise_m && tx_bits.size() > 0) so_drv = tx_bits.pop_front();
    if (bus.CS_out == 1'b0) begin
      if (!sc_drv && sc_old) seen_fall = 1'b1;
      else if (sc_drv && !sc_old && seen_fall) cs_rises++;
    end else begin
      seen_fall = 1'b0;
    end
    bus.sub_clock = sc_drv;
    bus.SO_in     = so_drv;
    bus.start     = st;
    bus.byte_len  = len;
    rst           = r;
    @(posedge top_clk);
    #1;
    if (r) begin
      m_phase = PH_IDLE; m_cs = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
      m_rx = 8'h00; m_prev = 1'b0; m_bits.delete(); tx_bits.delete();
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      case (m_phase)
        PH_IDLE: if (st && len != 8'd0) begin
          m_phase = PH_ARM; m_total = 8 * int'(len); m_cnt = 0;
          m_cs = 1'b0; m_busy = 1'b1; m_bits.delete();
        end
        PH_ARM: if (fall_m) m_phase = PH_CAP;
        PH_CAP: if (rise_m) begin
          m_bits.push_back(so_drv);
          m_cnt++;
          if (m_bits.size() == 8) begin
            m_rx = assemble(0); m_valid = 1'b1; m_bits.delete();
          end
          if (m_cnt == m_total) m_phase = PH_REL;
        end
        PH_REL: if (fall_m) begin
          m_phase = PH_IDLE; m_cs = 1'b1; m_busy = 1'b0; m_done = 1'b1;
        end
        default: m_phase = PH_IDLE;
      endcase
      m_prev = sc_drv;
    end
    cmp("cs_out",   32'(bus.CS_out),   32'(m_cs));
    cmp("busy",     32'(bus.busy),     32'(m_busy));
    cmp("rx_data",  32'(bus.rx_data),  32'(m_rx));
    cmp("rx_valid", 32'(bus.rx_valid), 32'(m_valid));
    cmp("done",     32'(bus.done),     32'(m_done));
    if (bus.rx_valid === 1'b1) got.push_back(bus.rx_data);
    if (bus.done === 1'b1) done_cnt++;
  endtask

  // Start a burst and run until done, optionally firing a stray start at cycle extra_at.
  task automatic run_burst(input logic [7:0] len, input logic [2:0][7:0] w, input int extra_at);
    bit finished = 1'b0;
    got.delete(); done_cnt = 0; cs_rises = 0;
    for (int i = 0; i < int'(len) && i < 3; i++) push_byte(w[i]);
    step(1'b1, len, 1'b0);
    for (int c = 0; c < 3000 && !finished; c++) begin
      step((c == extra_at) ? 1'b1 : 1'b0, 8'd9, 1'b0);
      if (bus.done === 1'b1) finished = 1'b1;
    end
    if (!finished) cmp("burst_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [2:0][7:0] w;
    logic [7:0]      len;
    bit              ok;

    bus.sub_clock = 1'b0; bus.SO_in = 1'b0; bus.start = 1'b0; bus.byte_len = 8'd0;

    tbl[0] = '{len: 8'd1, wire_b: {8'h00, 8'h00, 8'hA5}, exp_valid: 1, exp_done: 1};
    tbl[1] = '{len: 8'd3, wire_b: {8'h00, 8'hFF, 8'h03}, exp_valid: 3, exp_done: 1};
    tbl[2] = '{len: 8'd1, wire_b: {8'h00, 8'h00, 8'h01}, exp_valid: 1, exp_done: 1};
    tbl[3] = '{len: 8'd2, wire_b: {8'h00, 8'hC3, 8'h5A}, exp_valid: 2, exp_done: 1};
    tbl[4] = '{len: 8'd1, wire_b: {8'h00, 8'h00, 8'h80}, exp_valid: 1, exp_done: 1};

    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    cmp("reset_cs", 32'(bus.CS_out), 32'd1);
    cmp("reset_rx_data", 32'(bus.rx_data), 32'h00);

    for (int v = 0; v < 5; v++) begin
      hp = (v % 3) + 1;
      repeat (v + 1) step(1'b0, 8'd0, 1'b0);
      run_burst(tbl[v].len, tbl[v].wire_b, -1);
      cmp("tbl_valid_count", 32'(got.size()), 32'(tbl[v].exp_valid));
      cmp("tbl_done_count", 32'(done_cnt), 32'(tbl[v].exp_done));
      cmp("tbl_cs_rises", 32'(cs_rises), 32'(8 * int'(tbl[v].len)));
      for (int b = 0; b < tbl[v].exp_valid && b < got.size(); b++)
        cmp("tbl_byte", 32'(got[b]), 32'(rx_of(tbl[v].wire_b[b])));
    end

    // byte_len = 0 must be ignored
    got.delete(); done_cnt = 0;
    step(1'b1, 8'd0, 1'b0);
    cmp("len0_busy", 32'(bus.busy), 32'd0);
    repeat (10) step(1'b0, 8'd0, 1'b0);
    cmp("len0_cs", 32'(bus.CS_out), 32'd1);
    cmp("len0_done", 32'(done_cnt), 32'd0);

    // Stray start mid-burst changes nothing
    hp = 2;
    run_burst(8'd2, {8'h00, 8'h3C, 8'h96}, 6);
    cmp("midstart_count", 32'(got.size()), 32'd2);
    cmp("midstart_rises", 32'(cs_rises), 32'd16);
    cmp("midstart_done", 32'(done_cnt), 32'd1);

    // Mid-burst reset after 4 bits, then a clean 0x5A burst
    got.delete(); done_cnt = 0;
    push_byte(8'hF0); push_byte(8'h0F);
    step(1'b1, 8'd2, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      step(1'b0, 8'd0, 1'b0);
      if (m_cnt == 4 && m_phase == PH_CAP) ok = 1'b1;
    end
    cmp("midrst_reached", 32'(ok), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    cmp("midrst_cs", 32'(bus.CS_out), 32'd1);
    repeat (20) step(1'b0, 8'd0, 1'b0);
    cmp("midrst_no_valid", 32'(got.size()), 32'd0);
    cmp("midrst_no_done", 32'(done_cnt), 32'd0);
    run_burst(8'd1, {8'h00, 8'h00, 8'h5A}, -1);
    cmp("after_rst_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) cmp("after_rst_byte", 32'(got[0]), 32'(rx_of(8'h5A)));

    // Randomized bursts, sometimes back to back with start in the done cycle
    for (int n = 0; n < 10; n++) begin
      hp  = $urandom_range(1, 4);
      len = 8'($urandom_range(1, 3));
      w   = {8'($urandom), 8'($urandom), 8'($urandom)};
      repeat ($urandom_range(0, 3)) step(1'b0, 8'd0, 1'b0);
      run_burst(len, w, int'($urandom_range(0, 40)));
      cmp("rnd_count", 32'(got.size()), 32'(len));
      cmp("rnd_done", 32'(done_cnt), 32'd1);
      for (int b = 0; b < int'(len) && b < got.size(); b++)
        cmp("rnd_byte", 32'(got[b]), 32'(rx_of(w[b])));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
